// File: rtl/ctrl_decode_stage.sv
// rtl/ctrl_decode_stage.sv - registered RV32 main-control decode stage with divide hold
//
// Decodes the opcode of each accepted instruction into the main control
// bundle (plus M-extension control when EN_M=1), flags undecodable opcodes,
// and holds the bundle under a valid/ready handshake. Divide/remainder ops
// occupy the stage for DIV_CYCLES cycles before the bundle is presented.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid, in_ready   upstream handshake for instr
//   instr[31:0]          instruction word
//   flush                synchronous squash of the held entry (highest priority)
//   out_valid, out_ready downstream handshake for the control bundle
//   RegWrite, ImmSrc[2:0], ALUSrcA, ALUSrcB[1:0], MemWrite, ResultSrc[1:0],
//   Branch, ALUOp[1:0], Jump, PCJalSrc   control bundle
//   MulDiv               M-extension op
//   illegal              undecodable instruction
//   busy                 divide countdown in progress

module ctrl_decode_stage #(
   parameter bit EN_M       = 1'b1,
   parameter int DIV_CYCLES = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] instr,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        RegWrite,
   output logic [2:0]  ImmSrc,
   output logic        ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic        MemWrite,
   output logic [1:0]  ResultSrc,
   output logic        Branch,
   output logic [1:0]  ALUOp,
   output logic        Jump,
   output logic        PCJalSrc,
   output logic        MulDiv,
   output logic        illegal,
   output logic        busy
);

   localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(DIV_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [1:0] {
      S_EMPTY   = 2'd0,
      S_DIVWAIT = 2'd1,
      S_FULL    = 2'd2
   } state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic          accept;
   logic          load;

   logic [6:0]    op;
   logic [2:0]    funct3;
   logic [6:0]    funct7;

   // Decoded bundle, bit order:
   // RegWrite, ImmSrc[2:0], ALUSrcA, ALUSrcB[1:0], MemWrite, ResultSrc[1:0],
   // Branch, ALUOp[1:0], Jump, PCJalSrc
   logic [14:0]   dec_ctrl;
   logic          dec_muldiv;
   logic          dec_illegal;
   logic          dec_is_div;

   logic [14:0]   ctrl_q;
   logic          muldiv_q;
   logic          illegal_q;

   logic          unused_instr_bits;

   assign op     = instr[6:0];
   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];
   assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

   always_comb begin
      dec_ctrl    = '0;
      dec_muldiv  = 1'b0;
      dec_illegal = 1'b0;
      dec_is_div  = 1'b0;
      case (op)
         7'b0000011: dec_ctrl = 15'b1_000_0_01_0_01_0_00_0_0;  // lw
         7'b0010011: dec_ctrl = 15'b1_000_0_01_0_00_0_10_0_0;  // I-ALU
         7'b0010111: dec_ctrl = 15'b1_100_1_10_0_00_0_00_0_0;  // auipc
         7'b0100011: dec_ctrl = 15'b0_001_0_01_1_00_0_00_0_0;  // store
         7'b0110011: begin
            if (funct7 == 7'b0000001) begin
               if (EN_M) begin
                  dec_ctrl   = 15'b1_000_0_00_0_00_0_11_0_0;
                  dec_muldiv = 1'b1;
                  // funct3[2] separates div/rem from the mul family
                  dec_is_div = funct3[2];
               end else begin
                  dec_illegal = 1'b1;
               end
            end else begin
               dec_ctrl = 15'b1_000_0_00_0_00_0_10_0_0;        // R-ALU
            end
         end
         7'b0110111: dec_ctrl = 15'b1_100_1_01_0_00_0_00_0_0;  // lui
         7'b1100011: dec_ctrl = 15'b0_010_0_00_0_00_1_01_0_0;  // branch
         7'b1100111: dec_ctrl = 15'b1_000_0_01_0_10_0_00_1_0;  // jalr
         7'b1101111: dec_ctrl = 15'b1_011_0_00_0_10_0_00_1_1;  // jal
         7'b0000000: dec_ctrl = '0;                            // bubble
         default:    dec_illegal = 1'b1;
      endcase
   end

   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      in_ready = 1'b0;
      accept   = 1'b0;
      load     = 1'b0;
      case (state)
         S_EMPTY:   in_ready = 1'b1;
         S_FULL:    in_ready = out_ready;
         default:   in_ready = 1'b0;
      endcase
      accept = in_valid && in_ready;
      if (flush) begin
         state_n = S_EMPTY;
         cnt_n   = '0;
      end else if (accept) begin
         load = 1'b1;
         if (dec_is_div) begin
            state_n = S_DIVWAIT;
            cnt_n   = CNT_LOAD;
         end else begin
            state_n = S_FULL;
         end
      end else begin
         case (state)
            S_FULL: begin
               if (out_ready) state_n = S_EMPTY;
            end
            S_DIVWAIT: begin
               if (cnt == '0) state_n = S_FULL;
               else           cnt_n   = cnt - CNT_ONE;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_EMPTY;
         cnt       <= '0;
         ctrl_q    <= '0;
         muldiv_q  <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         if (load) begin
            ctrl_q    <= dec_ctrl;
            muldiv_q  <= dec_muldiv;
            illegal_q <= dec_illegal;
         end
      end
   end

   // The bundle registers already hold a divide's decode during DIVWAIT;
   // gating with FULL keeps it hidden until the countdown completes.
   assign out_valid = (state == S_FULL);
   assign busy      = (state == S_DIVWAIT);
   assign {RegWrite, ImmSrc, ALUSrcA, ALUSrcB, MemWrite, ResultSrc,
           Branch, ALUOp, Jump, PCJalSrc} = out_valid ? ctrl_q : 15'd0;
   assign MulDiv    = out_valid & muldiv_q;
   assign illegal   = out_valid & illegal_q;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// tb/tb_ctrl_decode_stage.sv - self-checking bench for ctrl_decode_stage

module tb_ctrl_decode_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] instr;
   logic        flush;
   logic        out_ready;

   logic        in_ready, out_valid, busy, MulDiv, illegal;
   logic        RegWrite, ALUSrcA, MemWrite, Branch, Jump, PCJalSrc;
   logic [2:0]  ImmSrc;
   logic [1:0]  ALUSrcB, ResultSrc, ALUOp;

   logic        n_in_ready, n_out_valid, n_busy, n_MulDiv, n_illegal;
   logic        n_RegWrite, n_ALUSrcA, n_MemWrite, n_Branch, n_Jump, n_PCJalSrc;
   logic [2:0]  n_ImmSrc;
   logic [1:0]  n_ALUSrcB, n_ResultSrc, n_ALUOp;

   logic [14:0] ctrl_act;
   assign ctrl_act = {RegWrite, ImmSrc, ALUSrcA, ALUSrcB, MemWrite, ResultSrc,
                      Branch, ALUOp, Jump, PCJalSrc};

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ctrl_decode_stage #(.EN_M(1'b1), .DIV_CYCLES(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .instr(instr), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .RegWrite(RegWrite), .ImmSrc(ImmSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .MemWrite(MemWrite), .ResultSrc(ResultSrc), .Branch(Branch), .ALUOp(ALUOp),
      .Jump(Jump), .PCJalSrc(PCJalSrc), .MulDiv(MulDiv), .illegal(illegal),
      .busy(busy)
   );

   ctrl_decode_stage #(.EN_M(1'b0), .DIV_CYCLES(2)) u_nom (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(n_in_ready),
      .instr(instr), .flush(flush), .out_valid(n_out_valid), .out_ready(out_ready),
      .RegWrite(n_RegWrite), .ImmSrc(n_ImmSrc), .ALUSrcA(n_ALUSrcA), .ALUSrcB(n_ALUSrcB),
      .MemWrite(n_MemWrite), .ResultSrc(n_ResultSrc), .Branch(n_Branch), .ALUOp(n_ALUOp),
      .Jump(n_Jump), .PCJalSrc(n_PCJalSrc), .MulDiv(n_MulDiv), .illegal(n_illegal),
      .busy(n_busy)
   );

   typedef struct {
      logic [31:0] instr;
      logic [14:0] ctrl;
      logic        md;
      logic        ill;
      logic        ill_nom;
   } vec_t;

   localparam int NV = 14;
   vec_t tbl [NV];

   localparam logic [31:0] I_LW  = 32'h00002083;
   localparam logic [31:0] I_JAL = 32'h008000EF;
   localparam logic [31:0] I_DIV = 32'h0220C1B3;
   localparam logic [14:0] C_LW  = 15'b1_000_0_01_0_01_0_00_0_0;
   localparam logic [14:0] C_JAL = 15'b1_011_0_00_0_10_0_00_1_1;
   localparam logic [14:0] C_MD  = 15'b1_000_0_00_0_00_0_11_0_0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int seen;
      int seq_idx [3];

      tbl[0]  = '{32'h00002083, 15'b1_000_0_01_0_01_0_00_0_0, 1'b0, 1'b0, 1'b0}; // lw
      tbl[1]  = '{32'h00108093, 15'b1_000_0_01_0_00_0_10_0_0, 1'b0, 1'b0, 1'b0}; // addi
      tbl[2]  = '{32'h00001097, 15'b1_100_1_10_0_00_0_00_0_0, 1'b0, 1'b0, 1'b0}; // auipc
      tbl[3]  = '{32'h0020A023, 15'b0_001_0_01_1_00_0_00_0_0, 1'b0, 1'b0, 1'b0}; // sw
      tbl[4]  = '{32'h002081B3, 15'b1_000_0_00_0_00_0_10_0_0, 1'b0, 1'b0, 1'b0}; // add
      tbl[5]  = '{32'h402081B3, 15'b1_000_0_00_0_00_0_10_0_0, 1'b0, 1'b0, 1'b0}; // sub
      tbl[6]  = '{32'h000010B7, 15'b1_100_1_01_0_00_0_00_0_0, 1'b0, 1'b0, 1'b0}; // lui
      tbl[7]  = '{32'h00208463, 15'b0_010_0_00_0_00_1_01_0_0, 1'b0, 1'b0, 1'b0}; // beq
      tbl[8]  = '{32'h000080E7, 15'b1_000_0_01_0_10_0_00_1_0, 1'b0, 1'b0, 1'b0}; // jalr
      tbl[9]  = '{32'h008000EF, 15'b1_011_0_00_0_10_0_00_1_1, 1'b0, 1'b0, 1'b0}; // jal
      tbl[10] = '{32'h022081B3, 15'b1_000_0_00_0_00_0_11_0_0, 1'b1, 1'b0, 1'b1}; // mul
      tbl[11] = '{32'h022091B3, 15'b1_000_0_00_0_00_0_11_0_0, 1'b1, 1'b0, 1'b1}; // mulh
      tbl[12] = '{32'h00000000, 15'b0,                        1'b0, 1'b0, 1'b0}; // bubble
      tbl[13] = '{32'h0000007F, 15'b0,                        1'b0, 1'b1, 1'b1}; // bad op

      rst_n = 1'b0; in_valid = 1'b0; instr = '0; flush = 1'b0; out_ready = 1'b1;

      // reset state
      #12;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ctrl", 32'({ctrl_act, MulDiv, illegal}), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);

      // single-instruction decode table
      for (int i = 0; i < NV; i++) begin
         instr = tbl[i].instr; in_valid = 1'b1; out_ready = 1'b1;
         tick();
         in_valid = 1'b0; instr = '0;
         @(negedge clk);
         chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'd1);
         chk($sformatf("v%0d_ctrl", i), 32'(ctrl_act), 32'(tbl[i].ctrl));
         chk($sformatf("v%0d_muldiv", i), 32'(MulDiv), 32'(tbl[i].md));
         chk($sformatf("v%0d_illegal", i), 32'(illegal), 32'(tbl[i].ill));
         chk($sformatf("v%0d_busy", i), 32'(busy), 32'd0);
         chk($sformatf("v%0d_nom_illegal", i), 32'(n_illegal), 32'(tbl[i].ill_nom));
         tick();
      end

      // back-to-back throughput: lw, add, jal
      seq_idx[0] = 0; seq_idx[1] = 4; seq_idx[2] = 9;
      instr = tbl[seq_idx[0]].instr; in_valid = 1'b1;
      tick();
      for (int k = 0; k < 3; k++) begin
         if (k < 2) instr = tbl[seq_idx[k+1]].instr;
         else       in_valid = 1'b0;
         @(negedge clk);
         chk($sformatf("b2b%0d_valid", k), 32'(out_valid), 32'd1);
         chk($sformatf("b2b%0d_ctrl", k), 32'(ctrl_act), 32'(tbl[seq_idx[k]].ctrl));
         tick();
      end

      // divide: busy for 8 cycles, bundle on the 8th edge
      instr = I_DIV; in_valid = 1'b1;
      tick();
      in_valid = 1'b0; instr = '0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk($sformatf("div_busy%0d", i), 32'(busy), 32'd1);
         chk($sformatf("div_in_ready%0d", i), 32'(in_ready), 32'd0);
         chk($sformatf("div_out_valid%0d", i), 32'(out_valid), 32'd0);
         if (i == 0) begin
            chk("div_nom_illegal", 32'(n_illegal), 32'd1);
            chk("div_nom_busy", 32'(n_busy), 32'd0);
         end
         @(posedge clk);
      end
      @(negedge clk);
      chk("div_done_valid", 32'(out_valid), 32'd1);
      chk("div_done_busy", 32'(busy), 32'd0);
      chk("div_done_ctrl", 32'({ctrl_act, MulDiv, illegal}), 32'({C_MD, 1'b1, 1'b0}));
      tick();

      // jal held under backpressure with lw waiting behind it
      instr = I_JAL; in_valid = 1'b1; out_ready = 1'b0;
      tick();
      instr = I_LW;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("hold%0d_valid", i), 32'(out_valid), 32'd1);
         chk($sformatf("hold%0d_ctrl", i), 32'(ctrl_act), 32'(C_JAL));
         chk($sformatf("hold%0d_in_ready", i), 32'(in_ready), 32'd0);
         @(posedge clk);
      end
      #1;
      out_ready = 1'b1;
      @(negedge clk);
      chk("release_in_ready", 32'(in_ready), 32'd1);
      chk("release_ctrl", 32'(ctrl_act), 32'(C_JAL));
      tick();
      in_valid = 1'b0; instr = '0;
      @(negedge clk);
      chk("after_hold_valid", 32'(out_valid), 32'd1);
      chk("after_hold_ctrl", 32'(ctrl_act), 32'(C_LW));
      tick();

      // flush three cycles into a divide
      instr = I_DIV; in_valid = 1'b1;
      tick();
      in_valid = 1'b0; instr = '0;
      @(posedge clk);
      @(posedge clk);
      #1;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      @(negedge clk);
      chk("flush_busy", 32'(busy), 32'd0);
      chk("flush_valid", 32'(out_valid), 32'd0);
      chk("flush_in_ready", 32'(in_ready), 32'd1);
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (out_valid || busy) seen++;
      end
      chk("flush_no_bundle", 32'(seen), 32'd0);
      tick();

      // flush on the cycle the divide would complete
      instr = I_DIV; in_valid = 1'b1;
      tick();
      in_valid = 1'b0; instr = '0;
      repeat (7) @(posedge clk);
      #1;
      flush = 1'b1;
      @(negedge clk);
      chk("flush_last_busy_before", 32'(busy), 32'd1);
      tick();
      flush = 1'b0;
      @(negedge clk);
      chk("flush_last_valid", 32'(out_valid), 32'd0);
      chk("flush_last_busy", 32'(busy), 32'd0);
      tick();

      // asynchronous reset mid-countdown
      instr = I_DIV; in_valid = 1'b1;
      tick();
      in_valid = 1'b0; instr = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rstmid_busy_before", 32'(busy), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rstmid_busy", 32'(busy), 32'd0);
      chk("rstmid_valid", 32'(out_valid), 32'd0);
      chk("rstmid_ctrl", 32'({ctrl_act, MulDiv, illegal}), 32'd0);
      chk("rstmid_in_ready", 32'(in_ready), 32'd1);
      tick();
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (out_valid || busy) seen++;
      end
      chk("rstmid_no_bundle", 32'(seen), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ctrl_decode_stage.md
# ctrl_decode_stage

Registered main-control decode stage for the pipelined RV32 core. It sits between the IF/ID register and the ID/EX register. It decodes each instruction's opcode into the standard control bundle, plus M-extension control when enabled, and holds the result under a valid/ready handshake. It adds illegal-opcode flagging, a flush path, and a multi-cycle hold for divide/remainder operations.

## Interface
- EN_M, default 1: 1 decodes M-extension ops (op 0110011, funct7 0000001); 0 flags them illegal.
- DIV_CYCLES, default 8, legal range 2..32: cycles a div/divu/rem/remu occupies the stage before out_valid.
- clk  in  1  clock, rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  instr is valid.
- in_ready  out  1  stage accepts instr this cycle.
- instr  in  32  instruction word; bits [6:0] op, [14:12] funct3, [31:25] funct7.
- flush  in  1  synchronous squash of the held entry.
- out_valid  out  1  control bundle valid.
- out_ready  in  1  downstream consumes the bundle.
- RegWrite, ALUSrcA, MemWrite, Branch, Jump, PCJalSrc  out  1 each  control bits.
- ImmSrc  out  3  immediate select.
- ALUSrcB, ResultSrc, ALUOp  out  2 each  selects.
- MulDiv  out  1  M-extension op.
- illegal  out  1  undecodable instruction.
- busy  out  1  divide countdown in progress.

## Operation
- Vector order is RegWrite_ImmSrc_ALUSrcA_ALUSrcB_MemWrite_ResultSrc_Branch_ALUOp_Jump_PCJalSrc.
  - 0000011 lw: 1_000_0_01_0_01_0_00_0_0
  - 0010011 I-ALU: 1_000_0_01_0_00_0_10_0_0
  - 0010111 auipc: 1_100_1_10_0_00_0_00_0_0
  - 0100011 S: 0_001_0_01_1_00_0_00_0_0
  - 0110011 R: 1_000_0_00_0_00_0_10_0_0
  - 0110111 lui: 1_100_1_01_0_00_0_00_0_0
  - 1100011 B: 0_010_0_00_0_00_1_01_0_0
  - 1100111 jalr: 1_000_0_01_0_10_0_00_1_0
  - 1101111 jal: 1_011_0_00_0_10_0_00_1_1
  - 0000000 bubble: all zero.
- The table contains no x values. Don't-care fields are driven 0.
- M-ext with EN_M=1 (op 0110011, funct7 0000001): R-type vector with ALUOp=11 and MulDiv=1.
  - funct3[2]=0 (mul family): single-cycle.
  - funct3[2]=1 (div family): multi-cycle.
- Any other opcode, or an M-op with EN_M=0: illegal=1 and all control bits 0.
- States:
  - EMPTY: in_ready=1.
  - DIVWAIT: busy=1, in_ready=0, out_valid=0.
  - FULL: out_valid=1, in_ready=out_ready.
- Transitions:
  - Accept = in_valid && in_ready.
  - EMPTY or FULL, accept of a non-div instruction → FULL with new bundle.
  - EMPTY or FULL, accept of a div instruction → DIVWAIT; counter loads DIV_CYCLES-1.
  - FULL && out_ready && !in_valid → EMPTY.
  - FULL && !out_ready → FULL; bundle held bit-stable.
  - DIVWAIT: counter decrements each cycle; at counter==0 → FULL.
- flush has priority over everything. Next state is EMPTY; any same-cycle input is dropped; counter clears.
- Counter width is $clog2(DIV_CYCLES). It never wraps, because the load value is at most DIV_CYCLES-1.

## Timing
- Reset, asserted asynchronously: state EMPTY, out_valid=0, busy=0, all controls, MulDiv and illegal 0, counter 0. in_ready=1 while in reset and after release.
- Non-div latency: accept at edge N → out_valid and bundle valid after edge N.
- Div latency: accept at edge N → busy=1 after edge N. Bundle and out_valid appear after edge N+DIV_CYCLES; busy falls on the same edge.
- Full throughput: back-to-back non-div instructions with out_ready=1 give one bundle per cycle.
- The bundle registers load only on accept. Outputs never change while out_valid && !out_ready.
- Reset asserted mid-DIVWAIT: immediate return to the reset state; no bundle is emitted.
- flush in the same cycle that DIVWAIT would complete: state goes to EMPTY and out_valid stays 0.

## Test plan
- Reset → release, then lw 0x00002083 with out_ready=1 → after 1 cycle out_valid=1, RegWrite=1, ALUSrcB=01, ResultSrc=01, all other controls 0, illegal=0.
- mul 0x022081B3 (EN_M=1) → after 1 cycle MulDiv=1, ALUOp=11, RegWrite=1, busy never set.
- div 0x0220C1B3 (DIV_CYCLES=8) → busy=1 for 8 cycles, in_ready=0 during them, out_valid rises on the 8th edge after accept.
- 0x0000007F → illegal=1, all controls 0. Repeat div 0x0220C1B3 with EN_M=0 → illegal=1.
- jal 0x008000EF followed by lw, with out_ready=0 for 3 cycles → jal bundle (ImmSrc=011, Jump=1, PCJalSrc=1, ResultSrc=10) held stable, in_ready=0. On out_ready=1, lw is accepted the same cycle and appears next cycle.
- Two abort cases:
  - div accepted, then flush 3 cycles later → EMPTY next cycle, busy=0, no out_valid.
  - div accepted, then rst_n pulsed low mid-countdown → all outputs 0 immediately.
